hazard_ctl: RTL
===============

HAZARD_CTL -- requirements
Module: hazard_ctl

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset; ports are named clk and rst_n.
REQ-002 SHALL have the ports listed in REQ-003 to REQ-017, as name, direction, width, meaning.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 d_valid  in  1  the D-stage instruction is real (not a bubble).
REQ-006 d_ra1, d_ra2  in  5 each  D-stage source register numbers.
REQ-007 d_tuse1, d_tuse2  in  2 each  cycles until the D instruction consumes each source (0 = consumed in D, 1 = consumed in E, 2/3 = never stalls).
REQ-008 d_we  in  1  the D instruction writes a register.
REQ-009 d_wa  in  5  the D instruction's destination register.
REQ-010 d_tnew  in  2  cycles after E entry until the result sits in a forwarding register (1 = ALU, 2 = load); 0 or 3 SHALL be treated as 1 and 2 respectively.
REQ-011 e_result  in  32  E-stage computed value, sampled on advance into M.
REQ-012 m_result  in  32  M-stage memory value, sampled on advance into W.
REQ-013 stall  out  1  freezes PC and the D register; inserts a bubble into E.
REQ-014 fwd_we1, fwd_wa1, fwd_wd1  out  1/5/32  M-stage forwarding source (higher priority).
REQ-015 fwd_we2, fwd_wa2, fwd_wd2  out  1/5/32  W-stage forwarding source.
REQ-016 stall_cnt  out  32  count of stalled cycles since reset.
REQ-017 Forwarding outputs SHALL be directly usable as the we1/wa1/wd1 and we2/wa2/wd2 inputs of the existing forwarding muxes in both D and E.

Function
REQ-018 Three producer entries, E, M and W, SHALL each hold we, wa[4:0], tnew[1:0] and wd[31:0]; E holds no wd.
REQ-019 Effective write enable SHALL be we && wa != 0; register 0 SHALL never match, stall or forward.
REQ-020 Stall condition, per source i with d_ra_i != 0: take the youngest entry (E, then M) whose effective we is set and whose wa == d_ra_i; stall is asserted if that entry's tnew > d_tuse_i.
REQ-021 An older matching entry SHALL be ignored once a younger one matches.
REQ-022 stall SHALL be the OR over both sources, gated by d_valid, and purely combinational from current state and D inputs.
REQ-023 Every rising edge SHALL advance W<=M, with tnew=0, wd=(M.tnew==0 ? M.wd : m_result).
REQ-024 Every rising edge SHALL advance M<=E, with tnew=sat(E.tnew-1), wd=e_result.
REQ-025 E<=D entry (we=d_we&&d_valid, wa=d_wa, tnew=normalized d_tnew) when stall==0; on stall, E<=bubble (we=0, wa=0, tnew=0).
REQ-026 M and W SHALL advance even during stall; there is no back-pressure beyond D.
REQ-027 fwd_we1=M.we&&M.wa!=0&&M.tnew==0; fwd_wa1=M.wa; fwd_wd1=M.wd.
REQ-028 fwd_we2=W.we&&W.wa!=0; fwd_wa2=W.wa; fwd_wd2=W.wd.
REQ-029 A load (tnew 2) reaching M SHALL have fwd_we1=0 while its M.tnew==1.
REQ-030 stall_cnt SHALL increment by 1 on every edge where stall==1, wrapping 0xFFFFFFFF->0.
REQ-031 Worst-case stall SHALL be 2 consecutive cycles (load followed by a tuse=0 consumer); no deadlock is possible because E always drains.

Reset
REQ-032 While rst_n==0, all entries SHALL be cleared (we=0, wa=0, tnew=0, wd=0) and stall_cnt=0, immediately and independent of clk.
REQ-033 During reset, stall=0 and all fwd_we*=0.
REQ-034 On reset deassertion mid-stall, the first edge SHALL accept the D entry (no residual stall).

Verification
REQ-035 ALU producer then tuse=1 consumer: D(we,wa=5,tnew=1), e_result=0x11 -> no stall; next cycle fwd_we1=1, fwd_wa1=5, fwd_wd1=0x11.
REQ-036 Load then branch: D(wa=8,tnew=2), next D reads r8 with tuse=0 -> stall=1 for 2 cycles; m_result=0xABCD appears as fwd_wd2 when fwd_we2=1; stall_cnt=2.
REQ-037 Load then ALU consumer: tuse=1, load wa=8 -> exactly 1 stall cycle, then fwd_we1=0 and fwd_we2=1 with wa=8.
REQ-038 Register 0: producer wa=0, consumer d_ra1=0 tuse=0 -> stall=0 and fwd_we1/2=0.
REQ-039 Priority: E and M both write r3; M ready (0x1), E tnew=2, consumer tuse=0 -> stall=1 (the older ready M entry does not cancel the stall).
REQ-040 Asynchronous reset asserted between edges during stall -> stall, fwd_we1/2 and stall_cnt drop to 0 before the next edge.

Source files
------------

// File: rtl/hazard_ctl.sv
// Pipeline hazard controller: tracks E/M/W producers, raises load-use stalls
// and presents M/W forwarding sources to the D- and E-stage bypass muxes.
module hazard_ctl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        d_valid,
  input  logic [4:0]  d_ra1,
  input  logic [4:0]  d_ra2,
  input  logic [1:0]  d_tuse1,
  input  logic [1:0]  d_tuse2,
  input  logic        d_we,
  input  logic [4:0]  d_wa,
  input  logic [1:0]  d_tnew,
  input  logic [31:0] e_result,
  input  logic [31:0] m_result,
  output logic        stall,
  output logic        fwd_we1,
  output logic [4:0]  fwd_wa1,
  output logic [31:0] fwd_wd1,
  output logic        fwd_we2,
  output logic [4:0]  fwd_wa2,
  output logic [31:0] fwd_wd2,
  output logic [31:0] stall_cnt
);

  localparam int unsigned RW = 5;
  localparam int unsigned TW = 2;
  localparam int unsigned DW = 32;

  logic          r_e_we;
  logic [RW-1:0] r_e_wa;
  logic [TW-1:0] r_e_tnew;
  logic          r_m_we;
  logic [RW-1:0] r_m_wa;
  logic [TW-1:0] r_m_tnew;
  logic [DW-1:0] r_m_wd;
  logic          r_w_we;
  logic [RW-1:0] r_w_wa;
  logic [DW-1:0] r_w_wd;
  logic [DW-1:0] r_stall_cnt;

  logic          w_e_eff;
  logic          w_m_eff;
  logic [TW-1:0] w_d_tnew;
  logic [TW-1:0] w_m_tnew_nxt;
  logic [DW-1:0] w_w_wd_nxt;
  logic          w_stall1;
  logic          w_stall2;
  logic          w_stall;

  // Youngest matching producer decides; an older match is shadowed.
  function automatic logic src_stall(
    input logic [RW-1:0] ra,
    input logic [TW-1:0] tuse,
    input logic          e_eff,
    input logic [RW-1:0] e_wa,
    input logic [TW-1:0] e_tnew,
    input logic          m_eff,
    input logic [RW-1:0] m_wa,
    input logic [TW-1:0] m_tnew
  );
    logic res;
    res = 1'b0;
    if (ra != '0) begin
      if (e_eff && (e_wa == ra)) begin
        res = (e_tnew > tuse);
      end else if (m_eff && (m_wa == ra)) begin
        res = (m_tnew > tuse);
      end
    end
    return res;
  endfunction

  always_comb begin
    w_e_eff = r_e_we && (r_e_wa != '0);
    w_m_eff = r_m_we && (r_m_wa != '0);

    // 0 behaves as an ALU result, 3 as a load.
    w_d_tnew = d_tnew;
    case (d_tnew)
      2'd0:    w_d_tnew = 2'd1;
      2'd3:    w_d_tnew = 2'd2;
      default: w_d_tnew = d_tnew;
    endcase

    w_m_tnew_nxt = (r_e_tnew == '0) ? '0 : TW'(r_e_tnew - TW'(1));
    w_w_wd_nxt   = (r_m_tnew == '0) ? r_m_wd : m_result;

    w_stall1 = src_stall(d_ra1, d_tuse1, w_e_eff, r_e_wa, r_e_tnew,
                         w_m_eff, r_m_wa, r_m_tnew);
    w_stall2 = src_stall(d_ra2, d_tuse2, w_e_eff, r_e_wa, r_e_tnew,
                         w_m_eff, r_m_wa, r_m_tnew);
    w_stall  = d_valid && (w_stall1 || w_stall2);
  end

  // M and W always drain; only E is replaced by a bubble on a stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_e_we      <= 1'b0;
      r_e_wa      <= '0;
      r_e_tnew    <= '0;
      r_m_we      <= 1'b0;
      r_m_wa      <= '0;
      r_m_tnew    <= '0;
      r_m_wd      <= '0;
      r_w_we      <= 1'b0;
      r_w_wa      <= '0;
      r_w_wd      <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_w_we   <= r_m_we;
      r_w_wa   <= r_m_wa;
      r_w_wd   <= w_w_wd_nxt;
      r_m_we   <= r_e_we;
      r_m_wa   <= r_e_wa;
      r_m_tnew <= w_m_tnew_nxt;
      r_m_wd   <= e_result;
      if (w_stall) begin
        r_e_we      <= 1'b0;
        r_e_wa      <= '0;
        r_e_tnew    <= '0;
        r_stall_cnt <= r_stall_cnt + DW'(1);
      end else begin
        r_e_we   <= d_we && d_valid;
        r_e_wa   <= d_wa;
        r_e_tnew <= w_d_tnew;
      end
    end
  end

  assign stall     = w_stall;
  assign fwd_we1   = w_m_eff && (r_m_tnew == '0);
  assign fwd_wa1   = r_m_wa;
  assign fwd_wd1   = r_m_wd;
  assign fwd_we2   = r_w_we && (r_w_wa != '0);
  assign fwd_wa2   = r_w_wa;
  assign fwd_wd2   = r_w_wd;
  assign stall_cnt = r_stall_cnt;

endmodule
